// File: rtl/reg_mem_arbiter.sv
// reg_mem_arbiter: round-robin arbiter sharing one reg_mem between clients A and B.
// Inputs:  clk, rst_n, req_a/b, we_a/b, addr_a/b, wdata_a/b, mem_dout.
// Outputs: gnt_a/b, rvalid_a/b, rdata_a/b, busy, mem_addr, mem_din, mem_wen.
module reg_mem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [ADDR_BITS-1:0]  addr_a,
    input  logic [ADDR_BITS-1:0]  addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  busy,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    logic [1:0] state;
    logic       last_gnt;
    logic       win;
    logic       lat_we;

    logic       any_req;
    logic       pick_b;
    logic       sel_we;
    logic [ADDR_BITS-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // B wins when alone, or on a tie when A was granted last.
    always_comb begin
        any_req = req_a | req_b;
        pick_b  = req_b & (~req_a | (last_gnt == SEL_A));
        sel_we    = pick_b ? we_b    : we_a;
        sel_addr  = pick_b ? addr_b  : addr_a;
        sel_wdata = pick_b ? wdata_b : wdata_a;
    end

    assign busy = (state != IDLE);

    // mem_addr / mem_din double as the latched address and write data,
    // so they hold their last values while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= SEL_B;
            win      <= SEL_A;
            lat_we   <= 1'b0;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_wen  <= 1'b0;
        end else begin
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            mem_wen  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win      <= pick_b;
                        last_gnt <= pick_b;
                        lat_we   <= sel_we;
                        mem_addr <= sel_addr;
                        mem_din  <= sel_wdata;
                        mem_wen  <= sel_we;
                        gnt_a    <= ~pick_b;
                        gnt_b    <= pick_b;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= lat_we ? IDLE : RDWAIT;
                end
                RDWAIT: begin
                    // Capturing at the end of RDWAIT suits both
                    // combinational and registered-read memories.
                    state <= IDLE;
                    if (win == SEL_B) begin
                        rdata_b  <= mem_dout;
                        rvalid_b <= 1'b1;
                    end else begin
                        rdata_a  <= mem_dout;
                        rvalid_a <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_mem_arbiter.sv
// tb_reg_mem_arbiter: scoreboard bench for reg_mem_arbiter with a
// registered-read memory model attached to the mem_* pins.
module tb_reg_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic       we_a = 1'b0, we_b = 1'b0;
    logic [4:0] addr_a = '0, addr_b = '0;
    logic [7:0] wdata_a = '0, wdata_b = '0;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b, busy, mem_wen;
    logic [7:0] rdata_a, rdata_b, mem_din, mem_dout;
    logic [4:0] mem_addr;

    always #5 clk = ~clk;

    reg_mem_arbiter #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b),
        .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b),
        .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .busy(busy),
        .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_wen(mem_wen), .mem_dout(mem_dout)
    );

    // Attached register memory, registered read port.
    logic [7:0] mem [32];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    typedef struct {
        bit       port;
        bit       we;
        bit [4:0] addr;
        bit [7:0] data;
    } acc_t;

    acc_t     exp_gnt[$];
    bit [7:0] exp_rd_a[$], exp_rd_b[$];
    int       rcyc_a[$], rcyc_b[$];
    int       compared = 0, mismatched = 0;
    int       cyc = 0;
    bit [7:0] model_mem[32];
    bit       model_last_b = 1'b1;
    logic [7:0] hold_a = '0, hold_b = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic acc_t mk(input bit p, input bit we,
                                input int a, input int d);
        acc_t m;
        m.port = p;
        m.we   = we;
        m.addr = a[4:0];
        m.data = d[7:0];
        return m;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a grant or read data.
    always @(negedge clk) begin
        acc_t e;
        if (rst_n) begin
            chk("gnt_excl", 32'(gnt_a & gnt_b), 0);
            chk("rvalid_excl", 32'(rvalid_a & rvalid_b), 0);
            if (gnt_a || gnt_b) begin
                if (exp_gnt.size() == 0) begin
                    chk("unexpected_gnt", 1, 0);
                end else begin
                    e = exp_gnt.pop_front();
                    chk("gnt_port_b", 32'(gnt_b), 32'(e.port));
                    chk("gnt_wen", 32'(mem_wen), 32'(e.we));
                    chk("gnt_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.we) chk("gnt_din", 32'(mem_din), 32'(e.data));
                    else if (e.port) rcyc_b.push_back(cyc + 2);
                    else rcyc_a.push_back(cyc + 2);
                end
            end else begin
                chk("idle_wen", 32'(mem_wen), 0);
            end
            if (rvalid_a) begin
                if (exp_rd_a.size() == 0) chk("unexpected_rvalid_a", 1, 0);
                else chk("rdata_a", 32'(rdata_a), 32'(exp_rd_a.pop_front()));
                if (rcyc_a.size() != 0)
                    chk("rvalid_a_cycle", cyc, rcyc_a.pop_front());
                hold_a = rdata_a;
            end else begin
                chk("rdata_a_hold", 32'(rdata_a), 32'(hold_a));
            end
            if (rvalid_b) begin
                if (exp_rd_b.size() == 0) chk("unexpected_rvalid_b", 1, 0);
                else chk("rdata_b", 32'(rdata_b), 32'(exp_rd_b.pop_front()));
                if (rcyc_b.size() != 0)
                    chk("rvalid_b_cycle", cyc, rcyc_b.pop_front());
                hold_b = rdata_b;
            end else begin
                chk("rdata_b_hold", 32'(rdata_b), 32'(hold_b));
            end
        end
    end

    always @(negedge rst_n) begin
        rcyc_a.delete();
        rcyc_b.delete();
        hold_a = '0;
        hold_b = '0;
    end

    task automatic check_zero();
        chk("rst_gnt_a", 32'(gnt_a), 0);
        chk("rst_gnt_b", 32'(gnt_b), 0);
        chk("rst_rvalid_a", 32'(rvalid_a), 0);
        chk("rst_rvalid_b", 32'(rvalid_b), 0);
        chk("rst_rdata_a", 32'(rdata_a), 0);
        chk("rst_rdata_b", 32'(rdata_b), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_din", 32'(mem_din), 0);
        chk("rst_mem_wen", 32'(mem_wen), 0);
    endtask

    // Reference: record the access the rules say wins next, with its result.
    task automatic predict(input bit pa, input bit pb,
                           input acc_t ha, input acc_t hb);
        bit   wb;
        acc_t op;
        wb = pb && (!pa || !model_last_b);
        model_last_b = wb;
        op = wb ? hb : ha;
        op.port = wb;
        exp_gnt.push_back(op);
        if (op.we) model_mem[op.addr] = op.data;
        else if (wb) exp_rd_b.push_back(model_mem[op.addr]);
        else exp_rd_a.push_back(model_mem[op.addr]);
    endtask

    // Drives two request streams until both are consumed.
    // Starts and ends with the DUT idle, just after a rising edge.
    task automatic run(input acc_t qa[$], input acc_t qb[$]);
        bit   prev_rd = 1'b0;
        int   waited;
        acc_t ha, hb, op;
        while (qa.size() != 0 || qb.size() != 0) begin
            req_a = (qa.size() != 0);
            req_b = (qb.size() != 0);
            ha = req_a ? qa[0] : mk(0, 0, 0, 0);
            hb = req_b ? qb[0] : mk(1, 0, 0, 0);
            if (req_a) begin
                we_a = ha.we; addr_a = ha.addr; wdata_a = ha.data;
            end
            if (req_b) begin
                we_b = hb.we; addr_b = hb.addr; wdata_b = hb.data;
            end
            predict(req_a, req_b, ha, hb);
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!(gnt_a || gnt_b) && waited < 8);
            chk("gnt_latency", waited, prev_rd ? 3 : 2);
            if (!(gnt_a || gnt_b)) begin
                req_a = 1'b0;
                req_b = 1'b0;
                repeat (6) @(posedge clk);
                #1;
                return;
            end
            if (gnt_a && qa.size() != 0) begin
                op = qa.pop_front();
                prev_rd = !op.we;
            end else if (gnt_b && qb.size() != 0) begin
                op = qb.pop_front();
                prev_rd = !op.we;
            end
            @(posedge clk);
            #1;
            // Latched at grant: corrupt every field; still-pending
            // streams are restored at the top of the loop.
            req_a = 1'b0; req_b = 1'b0;
            addr_a = ~addr_a; wdata_a = ~wdata_a; we_a = ~we_a;
            addr_b = ~addr_b; wdata_b = ~wdata_b; we_b = ~we_b;
        end
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        acc_t qa[$], qb[$], none[$];
        int   waited;
        foreach (model_mem[i]) model_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_zero();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Tie straight after reset: A first, then B.
        qa.push_back(mk(0, 1, 0, 8'hDF));
        qb.push_back(mk(1, 1, 1, 8'h3C));
        run(qa, qb);
        qa.delete(); qb.delete();
        qa.push_back(mk(0, 0, 0, 0));
        run(qa, none);
        qa.delete();

        // Sweep: A writes 223+i, B reads back.
        for (int i = 0; i < 32; i++) qa.push_back(mk(0, 1, i, 223 + i));
        run(qa, none);
        for (int i = 0; i < 32; i++) qb.push_back(mk(1, 0, i, 0));
        run(none, qb);
        qa.delete(); qb.delete();

        // Contention on address 3, then readback.
        qa.push_back(mk(0, 1, 3, 8'h11));
        qb.push_back(mk(1, 1, 3, 8'h22));
        for (int i = 0; i < 3; i++) begin
            qa.push_back(mk(0, 1, 8 + i, 8'h40 + i));
            qb.push_back(mk(1, 1, 12 + i, 8'h80 + i));
        end
        run(qa, qb);
        qa.delete(); qb.delete();
        qa.push_back(mk(0, 0, 3, 0));
        run(qa, none);
        qa.delete();

        // Randomised mixed traffic with frequent address collisions.
        repeat (40) begin
            repeat ($urandom_range(0, 3))
                qa.push_back(mk(0, 1'($urandom_range(0, 1)),
                                $urandom_range(0, 7), $urandom_range(0, 255)));
            repeat ($urandom_range(0, 3))
                qb.push_back(mk(1, 1'($urandom_range(0, 1)),
                                $urandom_range(0, 7), $urandom_range(0, 255)));
            run(qa, qb);
            qa.delete(); qb.delete();
        end

        // Reset while the read sits in RDWAIT.
        req_a = 1'b1; we_a = 1'b0; addr_a = 5'd7;
        predict(1'b1, 1'b0, mk(0, 0, 7, 0), mk(1, 0, 0, 0));
        void'(exp_rd_a.pop_back());
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!gnt_a && waited < 8);
        chk("abort_gnt_a", 32'(gnt_a), 1);
        @(posedge clk);
        #1;
        req_a = 1'b0;
        chk("rdwait_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero();
        model_last_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Fresh reads after reset; tie must again favour A.
        qa.push_back(mk(0, 0, 7, 0));
        qb.push_back(mk(1, 0, 3, 0));
        run(qa, qb);
        qa.delete(); qb.delete();

        repeat (6) @(posedge clk);
        chk("exp_gnt_left", exp_gnt.size(), 0);
        chk("exp_rd_a_left", exp_rd_a.size(), 0);
        chk("exp_rd_b_left", exp_rd_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
